// File: rtl/scan_mux_pkg.sv
// Shared definitions for the channel scan multiplexer: mode encodings, FSM states
// and the wrapping channel increment.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        StManual = MODE_MANUAL,
        StScan   = MODE_SCAN
    } state_e;

    localparam state_e STATE_RESET = StManual;

    // Explicit wrap so non-power-of-two channel counts never reach an empty index.
    function automatic int unsigned next_ch(input int unsigned cur, input int unsigned nch);
        return (cur >= nch - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/chan_out_reg.sv
// Single-entry valid/ready output register carrying a data word and its source channel.
// can_take tells the producer side whether a word may be loaded this cycle.
module chan_out_reg #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  data,
    input  logic [CW-1:0] ch,
    output logic          can_take,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_ch,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [W-1:0]  data_q;
    logic [CW-1:0] ch_q;
    logic          valid_q;

    // Full throughput: a draining word frees the slot in the same cycle.
    assign can_take  = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= data;
            ch_q    <= ch;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel registered multiplexer with valid/ready on every port; the current
// channel is either host-loaded (manual) or swept round-robin with an idle dwell (scan).
module chan_scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned SELW  = $clog2(NCH),
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic              sel_load,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_e            state_q, state_d;
    logic [SELW-1:0]   cur_ch_q, cur_ch_d;
    logic [CNTW-1:0]   dwell_q, dwell_d;
    logic              can_take;
    logic              take;
    logic              cur_valid;
    logic [W-1:0]      cur_data;
    logic [SELW-1:0]   adv_ch;
    logic              sel_ok;
    logic              dwell_done;

    always_comb begin
        cur_valid = 1'b0;
        cur_data  = '0;
        in_ready  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (cur_ch_q == SELW'(k)) begin
                cur_valid   = in_valid[k];
                cur_data    = in_data[k*W +: W];
                in_ready[k] = can_take && !rst;
            end
        end
    end

    assign take       = cur_valid && can_take && !rst;
    assign adv_ch     = SELW'(next_ch(32'(cur_ch_q), NCH));
    assign sel_ok     = 32'(sel) < NCH;
    assign dwell_done = dwell_q == CNTW'(DWELL - 1);

    always_comb begin
        state_d  = (mode == MODE_SCAN) ? StScan : StManual;
        cur_ch_d = cur_ch_q;
        dwell_d  = dwell_q;

        unique case (state_q)
            StManual: begin
                if (sel_load && sel_ok) begin
                    cur_ch_d = sel;
                end
            end
            StScan: begin
                if (take) begin
                    cur_ch_d = adv_ch;
                    dwell_d  = '0;
                end else if (!cur_valid) begin
                    if (dwell_done) begin
                        cur_ch_d = adv_ch;
                        dwell_d  = '0;
                    end else begin
                        dwell_d = dwell_q + CNTW'(1);
                    end
                end
                // Valid but backpressured: hold the channel and do not count.
            end
            default: begin
                state_d = STATE_RESET;
            end
        endcase

        if (state_d != state_q) begin
            dwell_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STATE_RESET;
            cur_ch_q <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            dwell_q  <= dwell_d;
        end
    end

    chan_out_reg #(
        .W  (W),
        .CW (SELW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (take),
        .data      (cur_data),
        .ch        (cur_ch_q),
        .can_take  (can_take),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input channel and on the output.
- Two modes:
  - Manual: the channel is loaded by the host.
  - Scan: round-robin sweep of all channels with an idle-dwell timeout.
- Sits between multiple producer channels and a single downstream consumer; successor to the fixed 8:1 combinational select.

Parameters:
- NCH, 8, number of input channels (2..64, need not be a power of two)
- W, 8, data width per channel
- SELW, $clog2(NCH), channel-index width (derived; do not override)
- DWELL, 4, cycles the scan waits on a channel with no in_valid before moving on (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NCH*W  channel k occupies bits [k*W +: W]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready; one-hot or zero
- mode  in  1  0 = manual, 1 = scan
- sel  in  SELW  manual channel index
- sel_load  in  1  load sel into the current channel
- out_data  out  W  registered selected data
- out_ch  out  SELW  channel index that out_data came from
- out_valid  out  1  output holds a word
- out_ready  in  1  consumer accepts a word

Behaviour:
- Reset (rst=1 at a clk edge): cur_ch=0, dwell_cnt=0, out_valid=0, out_data=0, out_ch=0, state=MANUAL. in_ready is 0 while rst is high.
- Accept condition: can_take = !out_valid || out_ready.
- in_ready[k] = can_take && (k==cur_ch). All other bits are 0.
- Transfer on channel k when in_valid[k] && in_ready[k]. At the next edge: out_data <= channel k data, out_ch <= k, out_valid <= 1. Latency is 1 cycle.
- Output drain: out_valid && out_ready with no new transfer -> out_valid <= 0.
- Simultaneous drain and capture gives full throughput: one word per cycle.
- out_data and out_ch stay stable while out_valid && !out_ready (AXI-style hold).
- State follows mode, registered each cycle: MANUAL <-> SCAN. A mode change takes effect on the next edge. An in-flight output word is not disturbed. dwell_cnt clears on any mode change.
- MANUAL:
  - sel_load=1 with sel<NCH -> cur_ch <= sel at the next edge.
  - sel>=NCH is ignored; cur_ch is unchanged.
  - The new channel's in_ready asserts the cycle after the load.
- SCAN:
  - sel_load is ignored.
  - After a transfer, cur_ch advances to the next channel and dwell_cnt <= 0.
  - If no transfer and in_valid[cur_ch]=0: dwell_cnt++. When dwell_cnt==DWELL-1, advance and clear the count.
  - If in_valid[cur_ch]=1 but the transfer is blocked by backpressure, hold the channel; dwell_cnt does not count.
  - Wrap: cur_ch==NCH-1 -> 0. Required for non-power-of-two NCH.
- Reset mid-operation discards the held output word and returns to channel 0, MANUAL.

Decomposition:
- Shared package scan_mux_pkg holds:
  - mode encodings MODE_MANUAL=1'b0, MODE_SCAN=1'b1
  - state localparams
  - a function next_ch(cur, NCH) implementing the wrap increment
- One natural sub-module: chan_out_reg, the single-entry valid/ready output register (data+ch payload, can_take generation). It is reusable on other streaming blocks.
- The channel select itself is an indexed part-select; no sub-module is needed.

Test Plan:
- Reset then manual: NCH=8, W=8, sel=5 + sel_load, in_valid[5]=1 with data 0xA5, out_ready=1 -> in_ready=8'h20 next cycle; out_data=0xA5, out_ch=5, out_valid=1 one cycle after the transfer.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_ch stable, in_ready=0. Release -> next word captured in the same cycle as the drain, no bubble.
- Scan with all channels valid, out_ready=1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles; one word per cycle.
- Scan dwell: only channel 3 valid, DWELL=4 -> channels 0..2 each held 4 cycles before advancing; channel 3 transfer at cycle 13 after reset release.
- Non-power-of-two: NCH=5 in scan -> out_ch wraps 4->0; sel=6 + sel_load in manual -> cur_ch unchanged.
- Reset mid-operation: rst asserted while out_valid=1 in SCAN on channel 6 -> next cycle out_valid=0, cur_ch=0, state MANUAL, in_ready=0 during reset.
